quad_gen: RTL and testbench
===========================

Name: quad_gen

Overview:
- Quadrature signal generator; the transmit-side counterpart of the team's quadrature decoder.
- Accepts single-cycle step requests (up/down) from control logic and accumulates them as a signed backlog.
- Emits rate-limited A/B quadrature edges until the backlog drains.
- Uses: encoder emulation, stepper-style position output, and loopback stimulus for the decoder.

Parameters:
- STEP_DIV, default 4: minimum clocks between successive A/B output edges. Legal range ≥1; 1 allows one edge per clock.
- PEND_W, default 8: width of the signed pending-step accumulator. Legal range ≥2.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- step_up  in  1  request one forward step; each high cycle counts once
- step_down  in  1  request one reverse step; each high cycle counts once
- quadA  out  1  quadrature output A, registered
- quadB  out  1  quadrature output B, registered
- pending  out  PEND_W  signed backlog of steps not yet emitted, two's complement
- busy  out  1  high while pending≠0 or the spacing timer≠0
- ovf  out  1  one-cycle pulse when a request was dropped by saturation

Behaviour:
- Reset, synchronous, sampled at rising clk with rst=1:
  - quadA=0, quadB=0, phase=0, pending=0, timer=0, ovf=0, busy=0.
  - Reset mid-operation discards the backlog immediately.
  - Requests in the reset cycle are ignored.
- Phase encoding, forward order of (A,B): 00 → 01 → 11 → 10 → 00.
  - Reverse is the exact opposite order.
  - Only one of A/B changes per edge, so no illegal transitions are ever emitted.
  - Forward edges make the team decoder pulse plus1; reverse edges make it pulse minus1.
- Edge issue, evaluated each clock on registered state:
  - fire = (timer==0) && (pending≠0).
  - dir = sign of pending: positive means forward, negative means reverse.
  - On fire: phase advances one step in dir, quadA/quadB update at that same edge, and timer loads STEP_DIV-1.
  - Otherwise, if timer≠0, timer decrements by 1.
- Accumulator update, every non-reset clock:
  - sum = pending + step_up − step_down − (fire ? dir : 0), computed in PEND_W+1 bits.
  - step_up and step_down high in the same cycle cancel: no change, no edge caused.
  - Clamp to the symmetric range [−(2^(PEND_W−1)−1), +(2^(PEND_W−1)−1)]. The most-negative code is never produced.
  - If clamped, pending takes the limit value and ovf=1 for the next cycle; otherwise ovf=0.
- Latency from idle (timer=0, pending=0):
  - step_up sampled at edge k gives pending=1 after k.
  - quadA/quadB change at edge k+1, pending returns to 0, timer=STEP_DIV-1.
  - busy rises after k and falls after edge k+STEP_DIV.
- Spacing:
  - With a sustained backlog, edges occur exactly every STEP_DIV clocks.
  - New requests arriving while the timer runs are queued, never dropped, unless saturated.
- Direction reversal:
  - If requests drive pending through zero, the next edge uses the new sign.
  - The spacing timer still applies, so there is no glitch or shortened interval between opposite-direction edges.
- busy = (pending≠0) || (timer≠0), registered-consistent: it is derived from post-update state.

Test Plan:
1. Reset check: hold rst=1 for 3 cycles with step_up=1 throughout -> quadA=quadB=0, pending=0, busy=0, ovf=0. Release rst mid-burst -> first edge follows exactly 2 cycles after the first non-reset step_up.
2. Single step, STEP_DIV=4: step_up pulse at cycle 10 -> pending=1 at cycle 11; (A,B)=01 at cycle 12; busy low from cycle 15.
3. Burst of 5: step_up high for cycles 0–4 -> (A,B) sequence 01,11,10,00,01 with edges at cycles 2,6,10,14,18; pending peaks at 4 and ends at 0.
4. Cancel, and reversal: step_up=step_down=1 for 3 cycles -> no edge, pending stays 0. Then 3× step_up followed by 5× step_down -> after the first forward edge, the remaining edges are reverse, with a net position of −2 and every edge spaced 4 cycles apart.
5. Saturation, PEND_W=4, STEP_DIV=64: step_up held for 12 cycles -> pending clamps at +7 (one edge already consumed); ovf pulses once per dropped request; later drain emits exactly 8 forward edges in total.
6. Loopback: connect quadA/quadB to the team decoder and issue 100 random up/down requests with STEP_DIV=2 -> decoder plus1 count minus minus1 count equals the requested net; no cycle where both A and B toggle.

Source files
------------

// File: rtl/quad_gen.sv
// Quadrature signal generator: accumulates up/down step requests as a signed
// backlog and emits rate-limited Gray-coded A/B edges until it drains.
module quad_gen #(
  parameter int STEP_DIV = 4,
  parameter int PEND_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step_up,
  input  logic                     step_down,
  output logic                     quadA,
  output logic                     quadB,
  output logic signed [PEND_W-1:0] pending,
  output logic                     busy,
  output logic                     ovf
);

  localparam int TMR_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(STEP_DIV - 1);

  // Symmetric clamp limits; the most-negative code is never produced.
  localparam logic signed [PEND_W:0] P_MAX = {2'b00, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W:0] P_MIN = -P_MAX;
  localparam logic signed [PEND_W:0] ONE   = (PEND_W+1)'(1);

  logic [1:0]              ab_q, ab_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic signed [PEND_W-1:0] pending_q, pending_d;
  logic                    ovf_q, ovf_d;

  logic                    fire;
  logic                    dir_rev;
  logic signed [PEND_W:0]  sum;

  // Forward order of (A,B): 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] phase_fwd(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_fwd = 2'b01;
      2'b01:   phase_fwd = 2'b11;
      2'b11:   phase_fwd = 2'b10;
      default: phase_fwd = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] phase_rev(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_rev = 2'b10;
      2'b10:   phase_rev = 2'b11;
      2'b11:   phase_rev = 2'b01;
      default: phase_rev = 2'b00;
    endcase
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    ab_d    = ab_q;
    timer_d = timer_q;
    fire    = (timer_q == '0) && (pending_q != '0);
    dir_rev = pending_q[PEND_W-1];

    if (fire) begin
      ab_d    = dir_rev ? phase_rev(ab_q) : phase_fwd(ab_q);
      timer_d = TMR_RELOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end

    sum = {pending_q[PEND_W-1], pending_q};
    if (step_up)   sum = sum + ONE;
    if (step_down) sum = sum - ONE;
    if (fire)      sum = dir_rev ? sum + ONE : sum - ONE;

    pending_d = sum[PEND_W-1:0];
    ovf_d     = 1'b0;
    if (sum > P_MAX) begin
      pending_d = P_MAX[PEND_W-1:0];
      ovf_d     = 1'b1;
    end else if (sum < P_MIN) begin
      pending_d = P_MIN[PEND_W-1:0];
      ovf_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      ab_q      <= 2'b00;
      timer_q   <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      ab_q      <= ab_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign quadA   = ab_q[1];
  assign quadB   = ab_q[0];
  assign pending = pending_q;
  assign ovf     = ovf_q;
  assign busy    = (pending_q != '0) || (timer_q != '0);

endmodule

// File: tb/tb_quad_gen.sv
// Scoreboard bench for quad_gen: expected A/B edges are queued at stimulus
// time and popped by a monitor whenever an output edge appears.
module tb_quad_gen;

  typedef struct {
    logic [1:0] ab;
    int         cyc;
  } exp_edge_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up0 = 1'b0, dn0 = 1'b0;
  logic up1 = 1'b0, dn1 = 1'b0;
  logic up2 = 1'b0, dn2 = 1'b0;

  logic a0, b0, busy0, ovf0;
  logic a1, b1, busy1, ovf1;
  logic a2, b2, busy2, ovf2;
  logic signed [7:0] pend0;
  logic signed [3:0] pend1;
  logic signed [7:0] pend2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  exp_edge_t q0[$];
  exp_edge_t q1[$];
  logic [1:0] exp_ab0 = 2'b00;
  logic [1:0] prev0 = 2'b00, prev1 = 2'b00, prev2 = 2'b00;
  int plus_cnt = 0, minus_cnt = 0, illegal_cnt = 0;

  quad_gen #(.STEP_DIV(4), .PEND_W(8)) dut0 (
    .clk(clk), .rst(rst), .step_up(up0), .step_down(dn0),
    .quadA(a0), .quadB(b0), .pending(pend0), .busy(busy0), .ovf(ovf0)
  );

  quad_gen #(.STEP_DIV(64), .PEND_W(4)) dut1 (
    .clk(clk), .rst(rst), .step_up(up1), .step_down(dn1),
    .quadA(a1), .quadB(b1), .pending(pend1), .busy(busy1), .ovf(ovf1)
  );

  quad_gen #(.STEP_DIV(2), .PEND_W(8)) dut2 (
    .clk(clk), .rst(rst), .step_up(up2), .step_down(dn2),
    .quadA(a2), .quadB(b2), .pending(pend2), .busy(busy2), .ovf(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [1:0] ab);
    case (ab)
      2'b00:   fwd_of = 2'b01;
      2'b01:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b10;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  // Monitor: pops expected edges for dut0/dut1, decodes dut2 like the team decoder.
  always @(negedge clk) begin : monitor
    exp_edge_t e;
    if (mon_en) begin
      if ({a0, b0} != prev0) begin
        if (q0.size() == 0) begin
          check("dut0_unexpected_edge_ab", int'({a0, b0}), int'(prev0));
        end else begin
          e = q0.pop_front();
          check("dut0_edge_ab", int'({a0, b0}), int'(e.ab));
          check("dut0_edge_cycle", cyc, e.cyc);
        end
        prev0 = {a0, b0};
      end
      if ({a1, b1} != prev1) begin
        if (q1.size() == 0) begin
          check("dut1_unexpected_edge_ab", int'({a1, b1}), int'(prev1));
        end else begin
          e = q1.pop_front();
          check("dut1_edge_ab", int'({a1, b1}), int'(e.ab));
          check("dut1_edge_cycle", cyc, e.cyc);
        end
        prev1 = {a1, b1};
      end
      if ({a2, b2} != prev2) begin
        if (({a2, b2} ^ prev2) == 2'b11) illegal_cnt++;
        else if (fwd_of(prev2) == {a2, b2}) plus_cnt++;
        else minus_cnt++;
        prev2 = {a2, b2};
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push0(input logic [1:0] ab, input int c);
    q0.push_back('{ab: ab, cyc: c});
    exp_ab0 = ab;
  endtask

  task automatic push1(input logic [1:0] ab, input int c);
    q1.push_back('{ab: ab, cyc: c});
  endtask

  task automatic reset0();
    int k;
    k = cyc + 1;
    if (exp_ab0 != 2'b00) push0(2'b00, k);
    up0 = 1'b0;
    dn0 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_pending", int'(pend0), 0);
    check("reset_busy", int'(busy0), 0);
  endtask

  task automatic wait_idle(input int which, input int budget);
    logic b;
    for (int n = 0; n < budget; n++) begin
      b = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
      if (!b) break;
      tick();
    end
    b = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
    check($sformatf("dut%0d_idle_within_budget", which), int'(b), 0);
  endtask

  initial begin : stimulus
    int k;
    int ovf_cnt;
    int first_ovf;
    int net;
    int req;
    int r;
    logic [1:0] fwd_seq [8];
    fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    // Reset held with step_up asserted: everything stays cleared.
    up0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mon_en = 1'b1;
      check("rst_quadA", int'(a0), 0);
      check("rst_quadB", int'(b0), 0);
      check("rst_pending", int'(pend0), 0);
      check("rst_busy", int'(busy0), 0);
      check("rst_ovf", int'(ovf0), 0);
    end
    // Release mid-burst: first non-reset request at k, first edge at k+1.
    rst = 1'b0;
    k = cyc + 1;
    push0(2'b01, k + 1);
    push0(2'b11, k + 5);
    tick();
    tick();
    up0 = 1'b0;
    wait_idle(0, 20);
    check("release_pending_drained", int'(pend0), 0);

    // Single step.
    reset0();
    k = cyc + 1;
    push0(2'b01, k + 1);
    up0 = 1'b1;
    tick();
    up0 = 1'b0;
    check("single_pending_after_k", int'(pend0), 1);
    check("single_busy_after_k", int'(busy0), 1);
    tick();
    check("single_pending_after_edge", int'(pend0), 0);
    tick();
    tick();
    check("single_busy_before_fall", int'(busy0), 1);
    tick();
    check("single_busy_fall", int'(busy0), 0);

    // Burst of five.
    reset0();
    k = cyc + 1;
    push0(2'b01, k + 1);
    push0(2'b11, k + 5);
    push0(2'b10, k + 9);
    push0(2'b00, k + 13);
    push0(2'b01, k + 17);
    up0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    up0 = 1'b0;
    check("burst_pending_peak", int'(pend0), 4);
    wait_idle(0, 40);
    check("burst_pending_end", int'(pend0), 0);
    check("burst_ovf", int'(ovf0), 0);

    // Simultaneous up and down cancel.
    reset0();
    up0 = 1'b1;
    dn0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cancel_pending", int'(pend0), 0);
      check("cancel_busy", int'(busy0), 0);
    end
    up0 = 1'b0;
    dn0 = 1'b0;

    // Three up then five down: one forward edge, then three reverse edges.
    k = cyc + 1;
    push0(2'b01, k + 1);
    push0(2'b00, k + 6);
    push0(2'b10, k + 10);
    push0(2'b11, k + 14);
    up0 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    up0 = 1'b0;
    dn0 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    dn0 = 1'b0;
    check("reverse_pending_negative", int'(pend0), -2);
    wait_idle(0, 40);
    check("reverse_pending_end", int'(pend0), 0);
    check("dut0_queue_drained", q0.size(), 0);

    // Saturation on the narrow accumulator with a slow edge rate.
    k = cyc + 1;
    for (int i = 0; i < 8; i++) push1(fwd_seq[i], k + 1 + 64 * i);
    ovf_cnt = 0;
    first_ovf = -1;
    up1 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 12) up1 = 1'b0;
      tick();
      if (ovf1) begin
        ovf_cnt++;
        if (first_ovf < 0) first_ovf = cyc;
      end
      if (i == 11) check("sat_pending_clamped", int'(pend1), 7);
    end
    check("sat_ovf_pulses", ovf_cnt, 4);
    check("sat_first_ovf_cycle", first_ovf, k + 8);
    wait_idle(1, 1000);
    check("sat_pending_end", int'(pend1), 0);
    check("dut1_queue_drained", q1.size(), 0);

    // Loopback into a decoder model with random single-cycle requests.
    net = 0;
    req = 0;
    while (req < 100) begin
      r = int'($urandom_range(0, 2));
      up2 = (r == 0);
      dn2 = (r == 1);
      if (r == 0) net++;
      if (r == 1) net--;
      if (r != 2) req++;
      tick();
    end
    up2 = 1'b0;
    dn2 = 1'b0;
    wait_idle(2, 500);
    check("loop_net_position", plus_cnt - minus_cnt, net);
    check("loop_edge_total", plus_cnt + minus_cnt >= (net < 0 ? -net : net) ? 1 : 0, 1);
    check("loop_illegal_transitions", illegal_cnt, 0);
    check("loop_pending_end", int'(pend2), 0);
    check("loop_ovf", int'(ovf2), 0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
